// File: rtl/estacao_reserva_r.sv
// estacao_reserva_r
// -----------------------------------------------------------------------------
// Reservation station for R-type ALU instructions in a Tomasulo datapath.
// Issued instructions are buffered in N_ENTRIES entries. Each entry snoops the
// CDB for missing operands. One ready entry at a time is dispatched to the R
// functional unit, and its result is broadcast on the CDB under the entry's tag.
//
// Ports
//   Clock, Reset                  : clock and synchronous active-high reset
//   Issue_valid/op/Vj/Vk/Qj/Qk    : issue request (Q = 0 means V already valid)
//   Issue_ready, Issue_tag        : a free entry exists / tag the next issue gets
//   Issue_ack                     : one-cycle pulse, issue accepted on last edge
//   CDB_valid/tag/data            : CDB snoop
//   A, B, Ufop, Ready_to_uf       : operands, operation and dispatch strobe to FU
//   Uf_done, Uf_write_enable      : FU completion flags
//   Uf_result                     : FU result
//   Cdb_req/_tag/_data, Cdb_grant : CDB write request and arbiter grant
//   Busy                          : at least one entry valid
// -----------------------------------------------------------------------------
module estacao_reserva_r #(
    parameter int N_ENTRIES = 3,
    parameter int TAG_W     = 3,
    parameter int BASE_TAG  = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Issue_valid,
    input  logic [2:0]       Issue_op,
    input  logic [15:0]      Issue_Vj,
    input  logic [15:0]      Issue_Vk,
    input  logic [TAG_W-1:0] Issue_Qj,
    input  logic [TAG_W-1:0] Issue_Qk,
    output logic             Issue_ready,
    output logic [TAG_W-1:0] Issue_tag,
    output logic             Issue_ack,
    input  logic             CDB_valid,
    input  logic [TAG_W-1:0] CDB_tag,
    input  logic [15:0]      CDB_data,
    output logic [15:0]      A,
    output logic [15:0]      B,
    output logic [2:0]       Ufop,
    output logic             Ready_to_uf,
    input  logic             Uf_done,
    input  logic             Uf_write_enable,
    input  logic [15:0]      Uf_result,
    output logic             Cdb_req,
    output logic [TAG_W-1:0] Cdb_req_tag,
    output logic [15:0]      Cdb_req_data,
    input  logic             Cdb_grant,
    output logic             Busy
);

    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DISPATCH  = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_BROADCAST = 2'd3;

    // Entry state
    logic [N_ENTRIES-1:0] valid_q, valid_d;
    logic [N_ENTRIES-1:0] disp_q,  disp_d;
    logic [2:0]           op_q [N_ENTRIES];
    logic [2:0]           op_d [N_ENTRIES];
    logic [15:0]          vj_q [N_ENTRIES];
    logic [15:0]          vj_d [N_ENTRIES];
    logic [15:0]          vk_q [N_ENTRIES];
    logic [15:0]          vk_d [N_ENTRIES];
    logic [TAG_W-1:0]     qj_q [N_ENTRIES];
    logic [TAG_W-1:0]     qj_d [N_ENTRIES];
    logic [TAG_W-1:0]     qk_q [N_ENTRIES];
    logic [TAG_W-1:0]     qk_d [N_ENTRIES];

    // FU-side state
    logic [1:0]       state_q,   state_d;
    logic [IDX_W-1:0] sel_q,     sel_d;
    logic [15:0]      a_q,       a_d;
    logic [15:0]      b_q,       b_d;
    logic [2:0]       ufop_q,    ufop_d;
    logic [15:0]      res_q,     res_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             ack_q,     ack_d;

    // Lowest free entry and lowest eligible entry, both from registered state
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             elig_found;
    logic [IDX_W-1:0] elig_idx;

    logic accept;
    logic bypass_j;
    logic bypass_k;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        elig_found = 1'b0;
        elig_idx   = '0;
        // Scanning downward leaves the lowest matching index in the result.
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (valid_q[i] && !disp_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0)) begin
                elig_found = 1'b1;
                elig_idx   = IDX_W'(i);
            end
        end
    end

    // The accepted R-type ops (010, 011, 110, 111) are exactly those with bit 1 set.
    assign accept   = Issue_valid && free_found && Issue_op[1];
    assign bypass_j = CDB_valid && (Issue_Qj != '0) && (Issue_Qj == CDB_tag);
    assign bypass_k = CDB_valid && (Issue_Qk != '0) && (Issue_Qk == CDB_tag);

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        valid_d   = valid_q;
        disp_d    = disp_q;
        op_d      = op_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        state_d   = state_q;
        sel_d     = sel_q;
        a_d       = a_q;
        b_d       = b_q;
        ufop_d    = ufop_q;
        res_d     = res_q;
        res_tag_d = res_tag_q;
        ack_d     = accept;

        // CDB snoop on every waiting operand of every valid entry
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (valid_q[i] && CDB_valid) begin
                if ((qj_q[i] != '0) && (qj_q[i] == CDB_tag)) begin
                    vj_d[i] = CDB_data;
                    qj_d[i] = '0;
                end
                if ((qk_q[i] != '0) && (qk_q[i] == CDB_tag)) begin
                    vk_d[i] = CDB_data;
                    qk_d[i] = '0;
                end
            end
        end

        // Allocation targets a currently free entry, so it never collides with
        // the snoop above (which only touches valid entries).
        if (accept) begin
            valid_d[free_idx] = 1'b1;
            disp_d[free_idx]  = 1'b0;
            op_d[free_idx]    = Issue_op;
            vj_d[free_idx]    = bypass_j ? CDB_data : Issue_Vj;
            qj_d[free_idx]    = bypass_j ? '0       : Issue_Qj;
            vk_d[free_idx]    = bypass_k ? CDB_data : Issue_Vk;
            qk_d[free_idx]    = bypass_k ? '0       : Issue_Qk;
        end

        case (state_q)
            ST_IDLE: begin
                if (elig_found) begin
                    state_d          = ST_DISPATCH;
                    sel_d            = elig_idx;
                    a_d              = vj_q[elig_idx];
                    b_d              = vk_q[elig_idx];
                    ufop_d           = op_q[elig_idx];
                    disp_d[elig_idx] = 1'b1;
                end
            end
            ST_DISPATCH: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (Uf_done || Uf_write_enable) begin
                    state_d   = ST_BROADCAST;
                    res_d     = Uf_result;
                    res_tag_d = TAG_W'(BASE_TAG) + TAG_W'(sel_q);
                end
            end
            ST_BROADCAST: begin
                // The freed entry is only visible as free after this edge,
                // so it cannot be reallocated on the same edge.
                if (Cdb_grant) begin
                    state_d        = ST_IDLE;
                    valid_d[sel_q] = 1'b0;
                    disp_d[sel_q]  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and FU-facing registers
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (Reset) begin
            valid_q   <= '0;
            disp_q    <= '0;
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ufop_q    <= '0;
            res_q     <= '0;
            res_tag_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            disp_q    <= disp_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ufop_q    <= ufop_d;
            res_q     <= res_d;
            res_tag_q <= res_tag_d;
            ack_q     <= ack_d;
        end
    end

    // NOTE: entry payload is not reset; it is only ever read while its valid bit is set.
    always_ff @(posedge Clock) begin
        op_q <= op_d;
        vj_q <= vj_d;
        vk_q <= vk_d;
        qj_q <= qj_d;
        qk_q <= qk_d;
    end

    assign Issue_ready  = free_found;
    assign Issue_tag    = free_found ? (TAG_W'(BASE_TAG) + TAG_W'(free_idx)) : '0;
    assign Issue_ack    = ack_q;
    assign A            = a_q;
    assign B            = b_q;
    assign Ufop         = ufop_q;
    assign Ready_to_uf  = (state_q == ST_DISPATCH);
    assign Cdb_req      = (state_q == ST_BROADCAST);
    assign Cdb_req_tag  = res_tag_q;
    assign Cdb_req_data = res_q;
    assign Busy         = |valid_q;

endmodule

// File: tb/tb_estacao_reserva_r.sv
// Directed testbench for estacao_reserva_r. Inputs change 1 ns after a rising
// edge and outputs are checked at the same point, i.e. they show the state
// registered on that edge.
module tb_estacao_reserva_r;

    localparam int TAG_W = 3;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             Issue_valid;
    logic [2:0]       Issue_op;
    logic [15:0]      Issue_Vj, Issue_Vk;
    logic [TAG_W-1:0] Issue_Qj, Issue_Qk;
    logic             Issue_ready;
    logic [TAG_W-1:0] Issue_tag;
    logic             Issue_ack;
    logic             CDB_valid;
    logic [TAG_W-1:0] CDB_tag;
    logic [15:0]      CDB_data;
    logic [15:0]      A, B;
    logic [2:0]       Ufop;
    logic             Ready_to_uf;
    logic             Uf_done, Uf_write_enable;
    logic [15:0]      Uf_result;
    logic             Cdb_req;
    logic [TAG_W-1:0] Cdb_req_tag;
    logic [15:0]      Cdb_req_data;
    logic             Cdb_grant;
    logic             Busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    estacao_reserva_r #(.N_ENTRIES(3), .TAG_W(TAG_W), .BASE_TAG(1)) dut (
        .Clock(Clock), .Reset(Reset),
        .Issue_valid(Issue_valid), .Issue_op(Issue_op),
        .Issue_Vj(Issue_Vj), .Issue_Vk(Issue_Vk),
        .Issue_Qj(Issue_Qj), .Issue_Qk(Issue_Qk),
        .Issue_ready(Issue_ready), .Issue_tag(Issue_tag), .Issue_ack(Issue_ack),
        .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
        .A(A), .B(B), .Ufop(Ufop), .Ready_to_uf(Ready_to_uf),
        .Uf_done(Uf_done), .Uf_write_enable(Uf_write_enable), .Uf_result(Uf_result),
        .Cdb_req(Cdb_req), .Cdb_req_tag(Cdb_req_tag), .Cdb_req_data(Cdb_req_data),
        .Cdb_grant(Cdb_grant), .Busy(Busy)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                         input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk);
        Issue_valid = 1'b1;
        Issue_op    = op;
        Issue_Vj    = vj;
        Issue_Vk    = vk;
        Issue_Qj    = qj;
        Issue_Qk    = qk;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Issue_valid = 1'b0; Issue_op = '0; Issue_Vj = '0; Issue_Vk = '0;
        Issue_Qj = '0; Issue_Qk = '0; CDB_valid = 1'b0; CDB_tag = '0; CDB_data = '0;
        Uf_done = 1'b0; Uf_write_enable = 1'b0; Uf_result = '0; Cdb_grant = 1'b0;

        // ---------------- reset state
        do_reset();
        check("rst_ready", Issue_ready, 1);
        check("rst_tag",   Issue_tag,   1);
        check("rst_busy",  Busy,        0);
        check("rst_req",   Cdb_req,     0);
        check("rst_rtu",   Ready_to_uf, 0);
        check("rst_ack",   Issue_ack,   0);
        check("rst_a",     A,           0);
        check("rst_reqtag", Cdb_req_tag, 0);

        // ---------------- minimum-latency ADD 5+3
        issue(3'b010, 16'd5, 16'd3, 0, 0);
        Uf_done = 1'b1; Uf_result = 16'd8; Cdb_grant = 1'b1;
        tick(); // E0
        Issue_valid = 1'b0;
        check("add_ack",   Issue_ack, 1);
        check("add_busy",  Busy,      1);
        check("add_tag2",  Issue_tag, 2);
        check("add_rtu0",  Ready_to_uf, 0);
        tick(); // E1
        check("add_ack_pulse", Issue_ack, 0);
        check("add_rtu",  Ready_to_uf, 1);
        check("add_a",    A,    5);
        check("add_b",    B,    3);
        check("add_op",   Ufop, 3'b010);
        tick(); // E2
        check("add_rtu_off", Ready_to_uf, 0);
        check("add_req0",    Cdb_req,     0);
        tick(); // E3
        check("add_req",     Cdb_req,      1);
        check("add_reqtag",  Cdb_req_tag,  1);
        check("add_reqdata", Cdb_req_data, 8);
        check("add_a_hold",  A,            5);
        tick(); // E4
        check("add_free_busy", Busy,    0);
        check("add_free_req",  Cdb_req, 0);
        check("add_free_tag",  Issue_tag, 1);
        Uf_done = 1'b0; Cdb_grant = 1'b0;

        // ---------------- illegal op is not accepted
        issue(3'b000, 16'd1, 16'd1, 0, 0);
        tick();
        Issue_valid = 1'b0;
        check("op000_ack",  Issue_ack, 0);
        check("op000_busy", Busy,      0);
        check("op000_tag",  Issue_tag, 1);
        issue(3'b100, 16'd1, 16'd1, 0, 0);
        tick();
        Issue_valid = 1'b0;
        check("op100_ack",  Issue_ack, 0);
        check("op100_busy", Busy,      0);

        // ---------------- SUB waiting on tag 2, captured from CDB
        issue(3'b011, 16'd0, 16'd4, 3'd2, 0);
        tick(); // E0
        Issue_valid = 1'b0;
        check("sub_ack", Issue_ack, 1);
        CDB_valid = 1'b1; CDB_tag = 3'd2; CDB_data = 16'd10;
        tick(); // E1: capture
        CDB_valid = 1'b0;
        check("sub_nodisp", Ready_to_uf, 0);
        tick(); // E2: dispatch register loaded
        check("sub_rtu", Ready_to_uf, 1);
        check("sub_a",   A,    10);
        check("sub_b",   B,    4);
        check("sub_op",  Ufop, 3'b011);
        Uf_done = 1'b1; Uf_result = 16'd6;
        tick(); // E3: WAIT_DONE
        tick(); // E4: BROADCAST
        check("sub_req",  Cdb_req,      1);
        check("sub_tag",  Cdb_req_tag,  1);
        check("sub_data", Cdb_req_data, 6);
        Uf_done = 1'b0; Cdb_grant = 1'b1;
        tick();
        Cdb_grant = 1'b0;
        check("sub_free", Busy, 0);

        // ---------------- issue-time bypass of Qk, completion via write-enable
        issue(3'b110, 16'd9, 16'd0, 0, 3'd3);
        CDB_valid = 1'b1; CDB_tag = 3'd3; CDB_data = 16'd7;
        tick(); // E0
        Issue_valid = 1'b0; CDB_valid = 1'b0;
        check("byp_ack", Issue_ack, 1);
        tick(); // E1
        check("byp_rtu", Ready_to_uf, 1);
        check("byp_a",   A,    9);
        check("byp_b",   B,    7);
        check("byp_op",  Ufop, 3'b110);
        Uf_write_enable = 1'b1; Uf_result = 16'h1234;
        tick(); // E2
        tick(); // E3
        Uf_write_enable = 1'b0; Uf_result = 16'h0;
        check("byp_req",  Cdb_req,      1);
        check("byp_data", Cdb_req_data, 16'h1234);
        tick(); // no grant: request holds
        check("byp_hold_req",  Cdb_req,      1);
        check("byp_hold_tag",  Cdb_req_tag,  1);
        check("byp_hold_data", Cdb_req_data, 16'h1234);
        check("byp_hold_a",    A,            9);
        Cdb_grant = 1'b1;
        tick();
        Cdb_grant = 1'b0;
        check("byp_free", Busy, 0);

        // ---------------- fill all entries while FU is held
        issue(3'b111, 16'd1, 16'd1, 0, 0);
        tick(); // E0 -> entry 0
        check("fill0_tag", Issue_tag, 2);
        issue(3'b010, 16'd2, 16'd2, 0, 0);
        tick(); // E1 -> entry 1, entry 0 dispatched
        check("fill1_tag", Issue_tag, 3);
        issue(3'b011, 16'd3, 16'd3, 0, 0);
        tick(); // E2 -> entry 2
        check("full_ready", Issue_ready, 0);
        check("full_ack",   Issue_ack,   1);
        issue(3'b010, 16'd4, 16'd4, 0, 0);
        tick(); // E3: 4th issue ignored
        Issue_valid = 1'b0;
        check("full_noack", Issue_ack,   0);
        check("full_ready2", Issue_ready, 0);
        Uf_done = 1'b1; Uf_result = 16'h55;
        tick(); // E4: BROADCAST
        Uf_done = 1'b0;
        check("full_req",    Cdb_req,      1);
        check("full_reqtag", Cdb_req_tag,  1);
        check("full_data",   Cdb_req_data, 16'h55);
        check("full_a",      A,            1);
        check("full_op",     Ufop,         3'b111);
        Cdb_grant = 1'b1;
        tick(); // E5: entry 0 freed
        Cdb_grant = 1'b0;
        check("freed_ready", Issue_ready, 1);
        check("freed_tag",   Issue_tag,   1);
        tick(); // E6: entry 1 dispatched
        check("next_rtu", Ready_to_uf, 1);
        check("next_a",   A,           2);
        Uf_done = 1'b1; Uf_result = 16'hbeef;
        tick(); // E7
        tick(); // E8: BROADCAST for tag 2
        Uf_done = 1'b0;
        check("next_req",    Cdb_req,     1);
        check("next_reqtag", Cdb_req_tag, 2);

        // ---------------- reset during BROADCAST without grant
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mrst_req",  Cdb_req,     0);
        check("mrst_busy", Busy,        0);
        check("mrst_tag",  Issue_tag,   1);
        check("mrst_rtu",  Ready_to_uf, 0);
        check("mrst_ready", Issue_ready, 1);
        tick();
        check("mrst_idle_rtu", Ready_to_uf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
